circ_buf_trig_sched: RTL
========================

# circ_buf_trig_sched

Trigger scheduler for circular-buffer acquisition. It runs in the ADC clock domain between the synchronized trigger and the circular-buffer readout state machine. On each accepted trigger it computes the buffer start address of the waveform, which is the write address minus the pre-trigger depth, modulo the buffer size. It waits until the post-trigger portion has been written, then enqueues the start address in a first-word-fall-through (FWFT) FIFO for the readout state machine to pop. It also enforces trigger holdoff and keeps accept/drop statistics.

## Interface
Parameters:
- `ADDR_W`, default 12: circular-buffer word-address width. The buffer size is 2^ADDR_W words.
- `FIFO_DEPTH`, default 4: trigger-address FIFO depth. Must be a power of 2 and ≥2.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1: ADC clock (400 MHz).
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `trig_pulse`  in  1: single-cycle trigger, already synchronized to `clk`.
- `acq_armed`  in  1: triggers are accepted only while high.
- `flush`  in  1: synchronous. Empties the FIFO, aborts any pending trigger, clears `overflow`.
- `clear_cnt`  in  1: synchronous. Zeroes `accept_cnt` and `drop_cnt`.
- `wr_addr`  in  ADDR_W: buffer address being written this cycle.
- `pre_trig`  in  ADDR_W: number of words kept before the trigger.
- `wfm_len`  in  ADDR_W: total number of words per waveform.
- `trig_addr_rd_en`  in  1: pop the FIFO head.
- `trig_addr`  out  ADDR_W: FIFO head (FWFT). Reset value 0.
- `trig_addr_valid`  out  1: FIFO is non-empty. Reset value 0.
- `busy`  out  1: a trigger is pending (state WAIT). Reset value 0.
- `overflow`  out  1: sticky; a completed trigger was lost because the FIFO was full. Reset value 0.
- `accept_cnt`  out  CNT_W: entries enqueued. Saturating. Reset value 0.
- `drop_cnt`  out  CNT_W: triggers lost to holdoff or a full FIFO. Saturating. Reset value 0.

## Operation
- State machine states: IDLE, WAIT.
- IDLE → WAIT when `trig_pulse && acq_armed && !flush`. On that transition:
  - latch `start = (wr_addr - pre_trig) mod 2^ADDR_W`;
  - load `post_cnt = wfm_len - pre_trig`.
- `post_cnt` legalization: if `pre_trig >= wfm_len`, or if `wfm_len - pre_trig` is 0, load 1 instead.
- `trig_pulse` is ignored while `acq_armed` is low and is not counted.
- In WAIT:
  - `post_cnt` decrements every cycle.
  - On the cycle `post_cnt == 1`, push `start` to the FIFO and return to IDLE.
- `trig_pulse` arriving while in WAIT (including on the push cycle) is the holdoff case: the trigger is discarded and `drop_cnt` increments.
- `acq_armed` low during WAIT: abort and return to IDLE. No push, no count.
- Full-FIFO push:
  - If the FIFO is full at push time and there is no simultaneous pop, the entry is discarded, `drop_cnt` increments and `overflow` sets.
  - A push and a pop in the same cycle while full both succeed; the count is unchanged.
- `accept_cnt` increments on every successful push.
- Pop while empty is ignored. Push and pop in the same cycle while empty: the entry is enqueued and the pop is ignored.
- If one cycle produces both a holdoff drop and a full-FIFO drop, `drop_cnt` increments by 1 only.
- `flush` has priority over everything except `reset`. On the next edge: state IDLE, FIFO empty, `overflow` cleared. Counters are untouched.
- `clear_cnt` takes priority over a same-cycle increment.
- Counters saturate at all-ones.
- `busy` is high exactly while the state is WAIT.

## Timing
- Trigger accepted in cycle T, with `wr_addr` sampled in T:
  - WAIT occupies cycles T+1 … T+post_len;
  - the FIFO write happens at the edge ending cycle T+post_len;
  - `trig_addr_valid`/`trig_addr` update in cycle T+post_len+1.
- State is IDLE again in T+post_len+1, so a new trigger is accepted from that cycle.
- Minimum trigger spacing is post_len+1 cycles.
- Pop: `trig_addr_rd_en` in cycle P advances the head. The new head, or `valid` going low, is visible in P+1.
- All outputs are registered.
- `reset` asserted mid-WAIT or with a non-empty FIFO: all outputs go to their reset values immediately; `trig_pulse` is accepted from the first cycle after deassertion.

## Test plan
- Basic capture:
  - stimulus: ADDR_W=12, `pre_trig`=16, `wfm_len`=64, `wr_addr`=0x200 at trigger T;
  - required response: `busy` high T+1…T+48; `trig_addr`=0x1F0 and `valid`=1 at T+49; `accept_cnt`=1.
- Wrap-around and legalization:
  - stimulus 1: `wr_addr`=0x005, `pre_trig`=16;
  - required response 1: `trig_addr`=0xFF5;
  - stimulus 2: `pre_trig`=64, `wfm_len`=64;
  - required response 2: push after 1 WAIT cycle, `trig_addr`=`wr_addr`-64 mod 4096.
- Holdoff:
  - stimulus: second trigger at T+10, third trigger on the push cycle T+48;
  - required response: both discarded, `drop_cnt`=2, one FIFO entry; a trigger at T+49 is accepted.
- FIFO full:
  - stimulus: FIFO_DEPTH=4, five completed triggers, no pops;
  - required response: the fifth is discarded, `overflow`=1, `drop_cnt`=1, `accept_cnt`=4;
  - follow-up: a pop coincident with a push while full leaves 4 entries, `overflow` unchanged.
- Abort and flush:
  - stimulus 1: `acq_armed` deasserted mid-WAIT;
  - required response 1: no push, counters unchanged, `busy` low next cycle;
  - stimulus 2: `flush` with 3 entries queued;
  - required response 2: `valid`=0, `overflow`=0, `accept_cnt` retained.
- Reset and saturation:
  - stimulus 1: async `reset` mid-WAIT with 2 entries queued;
  - required response 1: all outputs 0 immediately;
  - stimulus 2: CNT_W=4 with 20 holdoff drops;
  - required response 2: `drop_cnt`=15; `clear_cnt` returns it to 0.

Source files
------------

// File: rtl/circ_buf_trig_sched.sv
// Trigger scheduler: turns accepted triggers into circular-buffer start addresses queued in an FWFT FIFO.
// Enqueue occurs post_len cycles after the trigger; a full FIFO drops the entry unless a pop frees a slot that same cycle.
module circ_buf_trig_sched_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         wr_acc,
   input  logic         rd_rdy,
   output logic         rd_vld,
   output logic [W-1:0] rd_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
   logic [AW:0]   count, count_nxt;
   logic          full, do_push, do_pop;
   logic [W-1:0]  head_nxt;

   assign full       = (count == FULL_CNT);
   assign do_pop     = rd_rdy && (count != '0);
   assign do_push    = wr_vld && (!full || rd_rdy);
   assign wr_acc     = do_push;
   assign rd_ptr_inc = rd_ptr + AW'(1);
   assign count_nxt  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

   // Head is kept in its own register so the FWFT output is a flop, not a memory mux.
   always_comb begin
      head_nxt = rd_dat;
      if (do_pop)
         head_nxt = (count == (AW+1)'(1)) ? wr_dat : mem[rd_ptr_inc];
      else if ((count == '0) && do_push)
         head_nxt = wr_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rd_vld <= 1'b0;
         rd_dat <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rd_vld <= 1'b0;
         rd_dat <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr_inc;
         count  <= count_nxt;
         rd_vld <= (count_nxt != '0);
         rd_dat <= head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= wr_dat;
   end
endmodule

module circ_buf_trig_sched #(
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trig_pulse,
   input  logic              acq_armed,
   input  logic              flush,
   input  logic              clear_cnt,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0] pre_trig,
   input  logic [ADDR_W-1:0] wfm_len,
   input  logic              trig_addr_rd_en,
   output logic [ADDR_W-1:0] trig_addr,
   output logic              trig_addr_valid,
   output logic              busy,
   output logic              overflow,
   output logic [CNT_W-1:0]  accept_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);
   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] start_q, start_nxt, post_cnt, post_nxt, post_len;
   logic              holdoff, push, push_acc, full_drop;

   // A post-trigger length of zero or less still needs one cycle to land the push.
   assign post_len  = (pre_trig >= wfm_len) ? ADDR_W'(1) : (wfm_len - pre_trig);
   assign full_drop = push && !push_acc;

   always_comb begin
      state_nxt = state;
      start_nxt = start_q;
      post_nxt  = post_cnt;
      holdoff   = 1'b0;
      push      = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
      end else if (state == IDLE) begin
         if (trig_pulse && acq_armed) begin
            state_nxt = WAIT;
            start_nxt = wr_addr - pre_trig;
            post_nxt  = post_len;
         end
      end else if (!acq_armed) begin
         state_nxt = IDLE;
      end else begin
         holdoff  = trig_pulse;
         post_nxt = post_cnt - ADDR_W'(1);
         if (post_cnt == ADDR_W'(1)) begin
            push      = 1'b1;
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         start_q  <= '0;
         post_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         start_q  <= start_nxt;
         post_cnt <= post_nxt;
         busy     <= (state_nxt == WAIT);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         accept_cnt <= '0;
         drop_cnt   <= '0;
         overflow   <= 1'b0;
      end else begin
         if (clear_cnt) begin
            accept_cnt <= '0;
            drop_cnt   <= '0;
         end else begin
            if (push_acc && (accept_cnt != '1))
               accept_cnt <= accept_cnt + CNT_W'(1);
            if ((holdoff || full_drop) && (drop_cnt != '1))
               drop_cnt <= drop_cnt + CNT_W'(1);
         end
         if (flush)
            overflow <= 1'b0;
         else if (full_drop)
            overflow <= 1'b1;
      end
   end

   circ_buf_trig_sched_fifo #(
      .W     (ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .wr_vld (push),
      .wr_dat (start_q),
      .wr_acc (push_acc),
      .rd_rdy (trig_addr_rd_en),
      .rd_vld (trig_addr_valid),
      .rd_dat (trig_addr)
   );
endmodule
